data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder that sits at the MEM stage of the pipelined datapath, on the far side of the load/store interface.
- Accepts one load or store at a time from the pipeline's MemRead/MemWrite/address/write-data signals.
- Holds the pipeline with a stall signal for a fixed access latency, then returns read data or commits the store.
- Supports word, halfword and byte accesses with alignment checking.

---
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one load/store, stalls for LATENCY
// cycles, then pulses ready with formatted read data or commits the store.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic        stall,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        misalign
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          stateReg, stateNext;
    logic [3:0]      cntReg, cntNext;
    logic            accept;

    logic            reqWriteReg;
    logic [AW-1:0]   reqAddrReg;
    logic [31:0]     reqWdataReg;
    logic [1:0]      reqSizeReg;
    logic            reqUnsReg;

    logic            curWrite;
    logic [AW-1:0]   curAddr;
    logic [31:0]     curWdata;
    logic [1:0]      curSize;
    logic            curUns;
    logic            curMis;
    logic [IDX_W-1:0] curIdx;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     ramDoutReg;
    logic [3:0]      laneEn;
    logic [31:0]     laneData;
    logic            enterDone;
    logic            memWe;

    logic [1:0]      respSizeReg;
    logic [1:0]      respLaneReg;
    logic            respUnsReg;
    logic            respZeroReg;
    logic            respMisReg;

    logic [15:0]     halfSel;
    logic [7:0]      byteSel;
    logic            unusedAddrBits;

    assign unusedAddrBits = ^addr[31:AW];

    // With LATENCY = 1 the access completes straight out of IDLE, so the live
    // inputs are authoritative there; in BUSY only the latched copy is.
    always_comb begin
        curWrite = reqWriteReg;
        curAddr  = reqAddrReg;
        curWdata = reqWdataReg;
        curSize  = reqSizeReg;
        curUns   = reqUnsReg;
        if (stateReg == IDLE) begin
            curWrite = mem_write;
            curAddr  = addr[AW-1:0];
            curWdata = wdata;
            curSize  = size;
            curUns   = unsigned_ld;
        end
    end

    always_comb begin
        case (curSize)
            2'b01:   curMis = curAddr[0];
            2'b10:   curMis = 1'b0;
            default: curMis = |curAddr[1:0];
        endcase
    end

    assign curIdx = curAddr[AW-1:2];

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        stall     = 1'b0;
        accept    = 1'b0;
        case (stateReg)
            IDLE: begin
                stall = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = BUSY;
                        cntNext   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                stall   = 1'b1;
                cntNext = cntReg - 4'd1;
                if (cntReg == 4'd1) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A reset on the completing edge aborts the access: no commit, no capture.
    assign enterDone = (stateNext == DONE) && !rst;
    assign memWe     = enterDone && curWrite && !curMis;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            cntReg      <= 4'd0;
            respSizeReg <= 2'b00;
            respLaneReg <= 2'b00;
            respUnsReg  <= 1'b0;
            respZeroReg <= 1'b1;
            respMisReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                reqWriteReg <= mem_write;
                reqAddrReg  <= addr[AW-1:0];
                reqWdataReg <= wdata;
                reqSizeReg  <= size;
                reqUnsReg   <= unsigned_ld;
            end
            if (enterDone) begin
                respSizeReg <= curSize;
                respLaneReg <= curAddr[1:0];
                respUnsReg  <= curUns;
                respZeroReg <= curWrite | curMis;
                respMisReg  <= curMis;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign laneEn[gi] = (curSize == 2'b01) ? (curAddr[1] == 1'(gi / 2)) :
                                (curSize == 2'b10) ? (curAddr[1:0] == 2'(gi)) : 1'b1;
            assign laneData[gi*8 +: 8] = (curSize == 2'b01) ? curWdata[(gi % 2)*8 +: 8] :
                                         (curSize == 2'b10) ? curWdata[7:0] :
                                                              curWdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (enterDone) ramDoutReg <= mem[curIdx];
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (laneEn[b]) mem[curIdx][b*8 +: 8] <= laneData[b*8 +: 8];
            end
        end
    end

    // Response fields only change on DONE entry, so rdata holds between accesses.
    always_comb begin
        halfSel = respLaneReg[1] ? ramDoutReg[31:16] : ramDoutReg[15:0];
        byteSel = ramDoutReg[{respLaneReg, 3'b000} +: 8];
        case (respSizeReg)
            2'b01:   rdata = respUnsReg ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
            2'b10:   rdata = respUnsReg ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
            default: rdata = ramDoutReg;
        endcase
        if (respZeroReg) rdata = 32'h0;
    end

    assign ready    = (stateReg == DONE);
    assign misalign = (stateReg == DONE) && respMisReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 4, 1) driven with
// directed and random accesses, checked cycle by cycle against a word-array model.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rdReq;
    logic [2:0]  wrReq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  stallV;
    logic [2:0]  readyV;
    logic [2:0]  misV;
    logic [31:0] rdataV [3];

    int totalCount = 0;
    int badCount   = 0;
    logic [31:0] model [3][1024];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_read(rdReq[0]), .mem_write(wrReq[0]),
        .addr(addr), .wdata(wdata), .size(size), .unsigned_ld(uns),
        .stall(stallV[0]), .ready(readyV[0]), .rdata(rdataV[0]), .misalign(misV[0]));
    data_mem_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_read(rdReq[1]), .mem_write(wrReq[1]),
        .addr(addr), .wdata(wdata), .size(size), .unsigned_ld(uns),
        .stall(stallV[1]), .ready(readyV[1]), .rdata(rdataV[1]), .misalign(misV[1]));
    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_read(rdReq[2]), .mem_write(wrReq[2]),
        .addr(addr), .wdata(wdata), .size(size), .unsigned_ld(uns),
        .stall(stallV[2]), .ready(readyV[2]), .rdata(rdataV[2]), .misalign(misV[2]));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic int latOf(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 1;
    endfunction

    // Reference: word array per instance; sub-word ops by shift and mask.
    task automatic modelAccess(input int k, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [1:0] sz, input bit u,
                               output logic [31:0] expData, output bit expMis);
        int unsigned idx;
        int sh;
        logic [31:0] w;
        logic [31:0] v;
        idx = (a >> 2) % 1024;
        w = model[k][idx];
        expMis = (sz == 2'b01) ? a[0] : (sz == 2'b10) ? 1'b0 : (a[1:0] != 2'b00);
        expData = 32'h0;
        if (wr) begin
            if (!expMis) begin
                if (sz == 2'b01) begin
                    sh = 16 * int'(a[1]);
                    w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                end else if (sz == 2'b10) begin
                    sh = 8 * int'(a[1:0]);
                    w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                end else begin
                    w = wd;
                end
                model[k][idx] = w;
            end
        end else if (rd && !expMis) begin
            if (sz == 2'b01) begin
                v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
                if (!u && v[15]) v = v | 32'hFFFF0000;
            end else if (sz == 2'b10) begin
                v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
                if (!u && v[7]) v = v | 32'hFFFFFF00;
            end else begin
                v = w;
            end
            expData = v;
        end
    endtask

    task automatic xact(input int k, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input bit u,
                        input string tag, output logic [31:0] got);
        logic [31:0] expData;
        bit expMis;
        int lat;
        lat = latOf(k);
        modelAccess(k, rd, wr, a, wd, sz, u, expData, expMis);
        @(negedge clk);
        addr = a; wdata = wd; size = sz; uns = u; rdReq[k] = rd; wrReq[k] = wr;
        #1;
        checkVal({tag, "/stall_t"}, 32'(stallV[k]), 32'h1);
        checkVal({tag, "/ready_t"}, 32'(readyV[k]), 32'h0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rdReq[k] = 1'b0; wrReq[k] = 1'b0;
                addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
            end
            #1;
            if (c < lat) begin
                checkVal({tag, "/stall_busy"}, 32'(stallV[k]), 32'h1);
                checkVal({tag, "/ready_busy"}, 32'(readyV[k]), 32'h0);
            end else begin
                checkVal({tag, "/stall_done"}, 32'(stallV[k]), 32'h0);
                checkVal({tag, "/ready_done"}, 32'(readyV[k]), 32'h1);
                checkVal({tag, "/misalign"}, 32'(misV[k]), 32'(expMis));
                checkVal({tag, "/rdata"}, rdataV[k], expData);
                got = rdataV[k];
            end
        end
        @(negedge clk);
        #1;
        checkVal({tag, "/ready_after"}, 32'(readyV[k]), 32'h0);
        checkVal({tag, "/mis_after"}, 32'(misV[k]), 32'h0);
        checkVal({tag, "/rdata_hold"}, rdataV[k], expData);
        $display("xact %s k=%0d rd=%0d wr=%0d a=%08h sz=%0d u=%0d rdata=%08h mis=%0d",
                 tag, k, rd, wr, a, sz, u, got, expMis);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] eA;
        logic [31:0] eB;
        bit eMis;
        int op;
        logic [31:0] a;

        rst = 1'b1; rdReq = 3'b000; wrReq = 3'b000;
        addr = 32'h0; wdata = 32'h0; size = 2'b00; uns = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkVal("reset/stall", 32'(stallV[k]), 32'h0);
            checkVal("reset/ready", 32'(readyV[k]), 32'h0);
            checkVal("reset/rdata", rdataV[k], 32'h0);
            checkVal("reset/misalign", 32'(misV[k]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Word round trip, sub-word lanes, misalignment and wrap on LATENCY = 2.
        xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, "st10", got);
        xact(0, 1, 0, 32'h10, 32'h0, 2'b00, 0, "ld10", got);
        checkVal("ld10_const", got, 32'hDEADBEEF);
        xact(0, 0, 1, 32'h20, 32'h0, 2'b00, 0, "st20", got);
        xact(0, 0, 1, 32'h21, 32'h80, 2'b10, 0, "stb21", got);
        xact(0, 1, 0, 32'h20, 32'h0, 2'b00, 0, "ld20a", got);
        checkVal("ld20a_const", got, 32'h00008000);
        xact(0, 1, 0, 32'h21, 32'h0, 2'b10, 0, "ldsb21", got);
        checkVal("ldsb21_const", got, 32'hFFFFFF80);
        xact(0, 1, 0, 32'h21, 32'h0, 2'b10, 1, "ldub21", got);
        checkVal("ldub21_const", got, 32'h00000080);
        xact(0, 0, 1, 32'h22, 32'hBEEF, 2'b01, 0, "sth22", got);
        xact(0, 1, 0, 32'h20, 32'h0, 2'b00, 0, "ld20b", got);
        checkVal("ld20b_const", got, 32'hBEEF8000);
        xact(0, 1, 0, 32'h13, 32'h0, 2'b00, 0, "ldmis13", got);
        checkVal("ldmis13_const", got, 32'h0);
        xact(0, 0, 1, 32'h11, 32'h55555555, 2'b00, 0, "stmis11", got);
        xact(0, 1, 0, 32'h10, 32'h0, 2'b00, 0, "ld10b", got);
        checkVal("ld10b_const", got, 32'hDEADBEEF);
        xact(0, 0, 1, 32'h1000, 32'h12345678, 2'b00, 0, "st1000", got);
        xact(0, 1, 0, 32'h0, 32'h0, 2'b00, 0, "ld0wrap", got);
        checkVal("ld0wrap_const", got, 32'h12345678);

        // Reset in the second BUSY cycle of a LATENCY = 4 store aborts it.
        xact(1, 0, 1, 32'h40, 32'h0BADF00D, 2'b00, 0, "st40", got);
        @(negedge clk);
        addr = 32'h40; wdata = 32'hAAAA5555; size = 2'b00; uns = 1'b0; wrReq[1] = 1'b1;
        #1 checkVal("rstmid/stall_t", 32'(stallV[1]), 32'h1);
        @(negedge clk);
        wrReq[1] = 1'b0;
        #1 checkVal("rstmid/stall_b1", 32'(stallV[1]), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1 checkVal("rstmid/stall_b2", 32'(stallV[1]), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rstmid/stall_idle", 32'(stallV[1]), 32'h0);
        checkVal("rstmid/ready_idle", 32'(readyV[1]), 32'h0);
        checkVal("rstmid/rdata_idle", rdataV[1], 32'h0);
        $display("xact rstmid k=1 store 0xAAAA5555 aborted by reset");
        xact(1, 1, 0, 32'h40, 32'h0, 2'b00, 0, "ld40", got);
        checkVal("ld40_const", got, 32'h0BADF00D);

        // Seed a small word pool on every instance for the later phases.
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 8; w++)
                xact(k, 0, 1, 32'h100 + 32'(4 * w), $urandom, 2'b00, 0, "seed", got);

        // Back-to-back with LATENCY = 1: mem_read held through DONE.
        modelAccess(2, 1, 0, 32'h100, 32'h0, 2'b00, 0, eA, eMis);
        modelAccess(2, 1, 0, 32'h104, 32'h0, 2'b00, 0, eB, eMis);
        @(negedge clk);
        addr = 32'h100; size = 2'b00; uns = 1'b0; rdReq[2] = 1'b1;
        #1;
        checkVal("b2b/stall0", 32'(stallV[2]), 32'h1);
        checkVal("b2b/ready0", 32'(readyV[2]), 32'h0);
        @(negedge clk);
        addr = 32'h104;
        #1;
        checkVal("b2b/stall1", 32'(stallV[2]), 32'h0);
        checkVal("b2b/ready1", 32'(readyV[2]), 32'h1);
        checkVal("b2b/rdata1", rdataV[2], eA);
        @(negedge clk);
        #1;
        checkVal("b2b/stall2", 32'(stallV[2]), 32'h1);
        checkVal("b2b/ready2", 32'(readyV[2]), 32'h0);
        @(negedge clk);
        rdReq[2] = 1'b0;
        #1;
        checkVal("b2b/stall3", 32'(stallV[2]), 32'h0);
        checkVal("b2b/ready3", 32'(readyV[2]), 32'h1);
        checkVal("b2b/rdata3", rdataV[2], eB);
        $display("xact b2b k=2 loads 00000100 then 00000104");
        xact(2, 1, 1, 32'h108, 32'hC0FFEE11, 2'b00, 0, "rdwr108", got);
        xact(2, 1, 0, 32'h108, 32'h0, 2'b00, 0, "ld108", got);
        checkVal("ld108_const", got, 32'hC0FFEE11);

        // Random mix over the pool, with the 0x1000 alias exercising wrap.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 50; n++) begin
                op = int'($urandom_range(0, 3));
                a = 32'h100 + $urandom_range(0, 31) + ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0);
                xact(k, op != 1, op == 1 || op == 2, a, $urandom, 2'($urandom), 1'($urandom),
                     "rand", got);
            end
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end
endmodule
